// File: rtl/instruction_assembler_fifo_if.sv
// Instruction assembler bus bundle.
// Groups the byte-capture side, the decode-side valid/ready handshake and
// the status outputs. The design sits on the slave modport; the byte
// source / decode model drives through the master modport.
// Optional parity signals exist only when INSTRLATCH_PARITY_EN is defined.

interface instruction_assembler_fifo_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_INSTR = 2,
  parameter int DEPTH           = 4
);

  localparam int WORD_W = DATA_WIDTH * BYTES_PER_INSTR;
  localparam int IDX_W  = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                  i_capturebyte;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_flush;
  logic                  o_capture_ready;
  logic [IDX_W-1:0]      o_byte_index;
  logic                  o_instr_valid;
  logic                  i_instr_ready;
  logic [WORD_W-1:0]     o_instr;
  logic [CNT_W-1:0]      o_count;
  logic                  o_overflow;
`ifdef INSTRLATCH_PARITY_EN
  logic                  i_parity;
  logic                  o_parity_err;
`endif

  // Byte source and decode stage view
  modport master (
    output i_capturebyte,
    output i_data,
    output i_flush,
    output i_instr_ready,
`ifdef INSTRLATCH_PARITY_EN
    output i_parity,
    input  o_parity_err,
`endif
    input  o_capture_ready,
    input  o_byte_index,
    input  o_instr_valid,
    input  o_instr,
    input  o_count,
    input  o_overflow
  );

  // Assembler view
  modport slave (
    input  i_capturebyte,
    input  i_data,
    input  i_flush,
    input  i_instr_ready,
`ifdef INSTRLATCH_PARITY_EN
    input  i_parity,
    output o_parity_err,
`endif
    output o_capture_ready,
    output o_byte_index,
    output o_instr_valid,
    output o_instr,
    output o_count,
    output o_overflow
  );

endinterface

// File: rtl/instruction_assembler_fifo.sv
// Instruction assembler with show-ahead output FIFO.
// Collects BYTES_PER_INSTR byte-serial units (little-endian, byte 0 in the
// low bits) into one instruction word and queues finished words in a
// DEPTH-entry FIFO drained by the decode stage over valid/ready.
// Optional feature macro: INSTRLATCH_PARITY_EN (odd parity check per byte;
// a bad byte discards the partial word and pulses o_parity_err).

module instruction_assembler_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_INSTR = 2,
  parameter int DEPTH           = 4
) (
  input logic                   i_clk,
  input logic                   i_reset,
  instruction_assembler_fifo_if.slave bus
);

  localparam int WORD_W = DATA_WIDTH * BYTES_PER_INSTR;
  localparam int IDX_W  = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_INSTR - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE,
    COLLECT
  } asm_state_e;

  asm_state_e        state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [WORD_W-1:0] stage_q;
  logic [WORD_W-1:0] word_next;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic full, empty, last_slot, capture_ready;
  logic accept, parity_bad, push, pop, refused;

`ifdef INSTRLATCH_PARITY_EN
  logic parity_err_q;
  // Odd parity: data plus parity bit must hold an odd number of ones
  assign parity_bad = ~^{bus.i_data, bus.i_parity};
`else
  assign parity_bad = 1'b0;
`endif

  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  assign last_slot     = (index_q == LAST_IDX);
  // Only the word-completing byte needs FIFO room; a pop in the same cycle
  // does not free space early
  assign capture_ready = !(full && last_slot);

  // Flush wins over everything offered in the same cycle
  assign accept  = bus.i_capturebyte && capture_ready && !bus.i_flush;
  assign refused = bus.i_capturebyte && !capture_ready && !bus.i_flush;
  assign push    = accept && !parity_bad && last_slot;
  assign pop     = !empty && bus.i_instr_ready && !bus.i_flush;

  // Staging word with the offered byte dropped into the current slot
  always_comb begin
    word_next = stage_q;
    for (int s = 0; s < BYTES_PER_INSTR; s++) begin
      if (index_q == IDX_W'(s)) begin
        word_next[s*DATA_WIDTH +: DATA_WIDTH] = bus.i_data;
      end
    end
  end

  // Assembly state and slot index registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Next slot: advance on each good byte, wrap after the last slot or on a parity error
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    if (bus.i_flush) begin
      state_d = IDLE;
      index_d = '0;
    end else if (accept) begin
      if (parity_bad || last_slot) begin
        state_d = IDLE;
        index_d = '0;
      end else begin
        state_d = COLLECT;
        index_d = index_q + IDX_W'(1);
      end
    end
  end

  // Capture accepted bytes into the staging word
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stage_q <= '0;
    end else if (accept && !parity_bad) begin
      stage_q <= word_next;
    end
  end

  // FIFO storage; contents need no reset because empty reads are masked to zero
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= word_next;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow: set by a refused byte, cleared only by flush or reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      overflow_q <= 1'b0;
    end else if (bus.i_flush) begin
      overflow_q <= 1'b0;
    end else if (refused) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef INSTRLATCH_PARITY_EN
  // One-cycle pulse for each accepted byte that failed parity
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= accept && parity_bad;
    end
  end

  assign bus.o_parity_err = parity_err_q;
`endif

  assign bus.o_capture_ready = capture_ready;
  assign bus.o_byte_index    = index_q;
  assign bus.o_instr_valid   = !empty;
  assign bus.o_instr         = empty ? '0 : mem[rd_ptr_q];
  assign bus.o_count         = count_q;
  assign bus.o_overflow      = overflow_q;

endmodule

// File: tb/tb_instruction_assembler_fifo.sv
// Testbench for instruction_assembler_fifo.
// Directed test-plan sequence with literal expectations, then randomized
// traffic; a queue-based reference model is compared every cycle.

module tb_instruction_assembler_fifo;

  localparam int DW     = 8;
  localparam int BPI    = 2;
  localparam int DEPTH  = 4;
  localparam int WORD_W = DW * BPI;

  logic clk;
  logic rst;

  int n_cmp  = 0;
  int n_fail = 0;

  instruction_assembler_fifo_if #(
    .DATA_WIDTH(DW), .BYTES_PER_INSTR(BPI), .DEPTH(DEPTH)
  ) bus ();

  instruction_assembler_fifo #(
    .DATA_WIDTH(DW), .BYTES_PER_INSTR(BPI), .DEPTH(DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [WORD_W-1:0] mq[$];
  logic [DW-1:0]     mstage [BPI];
  int                midx = 0;
  bit                movf = 1'b0;

  function automatic bit model_ready();
    return !((mq.size() == DEPTH) && (midx == BPI - 1));
  endfunction

  task automatic check_output(input string name, input logic [63:0] got,
                              input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model update from the inputs presented at each rising edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      midx = 0;
      movf = 1'b0;
    end else if (bus.i_flush) begin
      mq.delete();
      midx = 0;
      movf = 1'b0;
    end else begin
      bit do_push;
      bit do_pop;
      logic [WORD_W-1:0] w;
      do_push = 1'b0;
      do_pop  = (mq.size() > 0) && bus.i_instr_ready;
      w = '0;
      if (bus.i_capturebyte) begin
        if (model_ready()) begin
          mstage[midx] = bus.i_data;
          if (midx == BPI - 1) begin
            for (int s = 0; s < BPI; s++) w[s*DW +: DW] = mstage[s];
            do_push = 1'b1;
            midx = 0;
          end else begin
            midx++;
          end
        end else begin
          movf = 1'b1;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(w);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check_output("capture_ready", 64'(bus.o_capture_ready), 64'(model_ready()));
      check_output("byte_index", 64'(bus.o_byte_index), 64'(midx));
      check_output("instr_valid", 64'(bus.o_instr_valid), 64'(mq.size() > 0));
      check_output("instr", 64'(bus.o_instr), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
      check_output("count", 64'(bus.o_count), 64'(mq.size()));
      check_output("overflow", 64'(bus.o_overflow), 64'(movf));
`ifdef INSTRLATCH_PARITY_EN
      check_output("parity_err", 64'(bus.o_parity_err), 64'd0);
`endif
    end
  end

  // One clock of stimulus; returns 1 time unit after the consuming edge
  task automatic apply_stimulus(input logic cap, input logic [DW-1:0] data,
                                input logic rdy, input logic flush);
    @(negedge clk);
    #1;
    bus.i_capturebyte = cap;
    bus.i_data        = data;
    bus.i_instr_ready = rdy;
    bus.i_flush       = flush;
`ifdef INSTRLATCH_PARITY_EN
    bus.i_parity      = ~^data;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_capture_ready"}, 64'(bus.o_capture_ready), 64'd1);
    check_output({tag, "_byte_index"}, 64'(bus.o_byte_index), 64'd0);
    check_output({tag, "_instr_valid"}, 64'(bus.o_instr_valid), 64'd0);
    check_output({tag, "_instr"}, 64'(bus.o_instr), 64'd0);
    check_output({tag, "_count"}, 64'(bus.o_count), 64'd0);
    check_output({tag, "_overflow"}, 64'(bus.o_overflow), 64'd0);
  endtask

  initial begin
    logic [WORD_W-1:0] fill_words [4];
    fill_words[0] = 16'h0201;
    fill_words[1] = 16'h0403;
    fill_words[2] = 16'h0605;
    fill_words[3] = 16'h0807;

    rst               = 1'b1;
    bus.i_capturebyte = 1'b0;
    bus.i_data        = '0;
    bus.i_instr_ready = 1'b0;
    bus.i_flush       = 1'b0;
`ifdef INSTRLATCH_PARITY_EN
    bus.i_parity      = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Two bytes little-endian into one word
    apply_stimulus(1'b1, 8'h34, 1'b0, 1'b0);
    check_output("t1_index_after_b0", 64'(bus.o_byte_index), 64'd1);
    check_output("t1_valid_after_b0", 64'(bus.o_instr_valid), 64'd0);
    apply_stimulus(1'b1, 8'h12, 1'b0, 1'b0);
    check_output("t1_valid", 64'(bus.o_instr_valid), 64'd1);
    check_output("t1_instr", 64'(bus.o_instr), 64'h1234);
    check_output("t1_count", 64'(bus.o_count), 64'd1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("t1_count_drained", 64'(bus.o_count), 64'd0);

    // Fill to capacity, stage one more byte, then overflow
    for (int b = 1; b <= 8; b++) apply_stimulus(1'b1, 8'(b), 1'b0, 1'b0);
    check_output("fill_count", 64'(bus.o_count), 64'd4);
    check_output("fill_ready_idx0", 64'(bus.o_capture_ready), 64'd1);
    apply_stimulus(1'b1, 8'h09, 1'b0, 1'b0);
    check_output("fill_index", 64'(bus.o_byte_index), 64'd1);
    check_output("fill_ready_blocked", 64'(bus.o_capture_ready), 64'd0);
    apply_stimulus(1'b1, 8'h0A, 1'b0, 1'b0);
    check_output("fill_overflow", 64'(bus.o_overflow), 64'd1);
    check_output("fill_index_held", 64'(bus.o_byte_index), 64'd1);
    check_output("fill_count_held", 64'(bus.o_count), 64'd4);

    // Drain in order
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("drain_head%0d", k), 64'(bus.o_instr), 64'(fill_words[k]));
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_output("drain_instr_empty", 64'(bus.o_instr), 64'd0);
    check_output("drain_count", 64'(bus.o_count), 64'd0);
    check_output("drain_overflow_sticky", 64'(bus.o_overflow), 64'd1);

    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("flush1_overflow", 64'(bus.o_overflow), 64'd0);
    check_output("flush1_index", 64'(bus.o_byte_index), 64'd0);

    // Simultaneous push and pop with two words held
    apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h22, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h33, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h44, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
    check_output("pp_count_before", 64'(bus.o_count), 64'd2);
    check_output("pp_head_before", 64'(bus.o_instr), 64'h2211);
    apply_stimulus(1'b1, 8'h66, 1'b1, 1'b0);
    check_output("pp_count_after", 64'(bus.o_count), 64'd2);
    check_output("pp_head_after", 64'(bus.o_instr), 64'h4433);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("pp_next_head", 64'(bus.o_instr), 64'h6655);

    // Flush with index=1 and three words, byte strobed in the same cycle
    apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h88, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h99, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hBB, 1'b0, 1'b0);
    check_output("fl_count_before", 64'(bus.o_count), 64'd3);
    check_output("fl_index_before", 64'(bus.o_byte_index), 64'd1);
    apply_stimulus(1'b1, 8'hCC, 1'b1, 1'b1);
    check_output("fl_index", 64'(bus.o_byte_index), 64'd0);
    check_output("fl_count", 64'(bus.o_count), 64'd0);
    check_output("fl_valid", 64'(bus.o_instr_valid), 64'd0);
    check_output("fl_overflow", 64'(bus.o_overflow), 64'd0);

    // Asynchronous reset mid-word
    for (int b = 1; b <= 5; b++) apply_stimulus(1'b1, 8'(8'hE0 + b), 1'b0, 1'b0);
    check_output("ar_count_before", 64'(bus.o_count), 64'd2);
    check_output("ar_index_before", 64'(bus.o_byte_index), 64'd1);
    @(negedge clk);
    bus.i_capturebyte = 1'b0;
    bus.i_instr_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      apply_stimulus(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                     8'($urandom()),
                     ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
